// File: rtl/fp8_pkg.sv
// Shared definitions for the 8-bit floating-point blocks (multiplier and adder):
// format constants, field selects and the multiplier's FSM states.
package fp8_pkg;

    localparam int         BIAS    = 3;
    localparam int         EXP_MAX = 7;
    localparam logic [6:0] SAT_MAG = 7'h7F;

    typedef enum logic [1:0] {IDLE, MUL, NORM, DONE} state_t;

    function automatic logic fp8_sign(input logic [7:0] x);
        return x[7];
    endfunction

    function automatic logic [2:0] fp8_exp(input logic [7:0] x);
        return x[6:4];
    endfunction

    function automatic logic [3:0] fp8_frac(input logic [7:0] x);
        return x[3:0];
    endfunction

endpackage

// File: rtl/fp8_normalize.sv
// Combinational pack of the raw significand product into fp8, with overflow
// saturation, underflow flush and zero-operand override.
module fp8_normalize #(
    parameter int MANT_W = 4
) (
    input  logic [2*(MANT_W+1)-1:0] acc,
    input  logic signed [5:0]       exp_sum,
    input  logic                    sign,
    input  logic                    zflag,
    output logic [7:0]              c,
    output logic                    ovf,
    output logic                    unf
);
    import fp8_pkg::*;

    localparam int ACC_W = 2 * (MANT_W + 1);

    logic signed [5:0]   e_norm;
    logic [MANT_W-1:0]   frac;

    function automatic logic [7:0] saturate(input logic s);
        return {s, SAT_MAG};
    endfunction

    always_comb begin
        // Product of two 1.x significands lies in [1,4): one bit of renormalisation at most.
        e_norm = exp_sum;
        frac   = acc[ACC_W-3 -: MANT_W];
        if (acc[ACC_W-1]) begin
            e_norm = exp_sum + 6'sd1;
            frac   = acc[ACC_W-2 -: MANT_W];
        end

        c   = '0;
        ovf = 1'b0;
        unf = 1'b0;
        if (!zflag) begin
            if (e_norm > 6'(EXP_MAX)) begin
                c   = saturate(sign);
                ovf = 1'b1;
            end else if (e_norm < 6'sd1) begin
                unf = 1'b1;
            end else begin
                c = {sign, e_norm[2:0], frac};
            end
        end
    end

endmodule

// File: rtl/fp8_seq_multiplier.sv
// Iterative fp8 multiplier: 5-cycle shift-add over the significands, one pack
// cycle, then a done pulse with the registered product, 7 cycles after start.
module fp8_seq_multiplier #(
    parameter int BIAS   = fp8_pkg::BIAS,
    parameter int MANT_W = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] A,
    input  logic [7:0] B,
    output logic       busy,
    output logic       done,
    output logic [7:0] C,
    output logic       ovf,
    output logic       unf
);
    import fp8_pkg::*;

    localparam int SIG_W = MANT_W + 1;
    localparam int ACC_W = 2 * SIG_W;
    localparam int CNT_W = $clog2(SIG_W);

    state_t             state, state_nxt;
    logic               accept;
    logic [CNT_W-1:0]   cnt;
    logic [SIG_W-1:0]   mcand, mplier;
    logic [ACC_W-1:0]   acc;
    logic signed [5:0]  exp_sum, exp_sum_in;
    logic               sign, zflag;
    logic [7:0]         c_p, c_n;
    logic               ovf_p, unf_p, ovf_n, unf_n;

    assign exp_sum_in = $signed({3'b000, fp8_exp(A)}) + $signed({3'b000, fp8_exp(B)}) - 6'(BIAS);

    fp8_normalize #(.MANT_W(MANT_W)) u_norm (
        .acc     (acc),
        .exp_sum (exp_sum),
        .sign    (sign),
        .zflag   (zflag),
        .c       (c_n),
        .ovf     (ovf_n),
        .unf     (unf_n)
    );

    // start is ignored while the done pulse is showing, so a held start re-arms one cycle later.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        case (state)
            IDLE: if (start && !done) begin
                accept    = 1'b1;
                state_nxt = MUL;
            end
            MUL:  if (cnt == CNT_W'(SIG_W - 1)) state_nxt = NORM;
            NORM: state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            C       <= 8'h00;
            ovf     <= 1'b0;
            unf     <= 1'b0;
            cnt     <= '0;
            mcand   <= '0;
            mplier  <= '0;
            acc     <= '0;
            exp_sum <= '0;
            sign    <= 1'b0;
            zflag   <= 1'b0;
            c_p     <= 8'h00;
            ovf_p   <= 1'b0;
            unf_p   <= 1'b0;
        end else begin
            state <= state_nxt;
            busy  <= (state == MUL) || (state == NORM);
            done  <= (state == DONE);
            case (state)
                // Operand capture
                IDLE: if (accept) begin
                    sign    <= fp8_sign(A) ^ fp8_sign(B);
                    exp_sum <= exp_sum_in;
                    mcand   <= {1'b1, fp8_frac(A)};
                    mplier  <= {1'b1, fp8_frac(B)};
                    acc     <= '0;
                    cnt     <= '0;
                    zflag   <= (fp8_exp(A) == 3'd0) || (fp8_exp(B) == 3'd0);
                end
                // Shift-add, one multiplier bit per cycle
                MUL: begin
                    if (mplier[cnt]) acc <= acc + (ACC_W'(mcand) << cnt);
                    cnt <= cnt + 1'b1;
                end
                // Pack result
                NORM: begin
                    c_p   <= c_n;
                    ovf_p <= ovf_n;
                    unf_p <= unf_n;
                end
                // Publish together with the done pulse
                DONE: begin
                    C   <= c_p;
                    ovf <= ovf_p;
                    unf <= unf_p;
                end
                default: ;
            endcase
        end
    end

endmodule
